mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/pipeline_defs.sv | 32 +++
 rtl/mem_stage_ctrl_load_extend.sv | 32 +++
 rtl/mem_stage_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: MEM stage FSM states,
// access size encodings and alignment helper.
package pipeline_defs;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } mem_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Reserved size 11 is handled as a word.
  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: ok = 1'b1;
      size == SZ_HALF: ok = ~a[0];
      default:         ok = (a == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_extend.sv
// Load lane select and zero/sign extension.
// Purely combinational.
import pipeline_defs::*;

module load_extend (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    b       = shifted[7:0];
    h       = addr[1] ? rdata[31:16] : rdata[15:0];
    data    = rdata;
    unique case (1'b1)
      size == SZ_BYTE:
        data = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
      size == SZ_HALF:
        data = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default:
        data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data memory requests,
// stalls the pipe, extends loads, handles flush/timeout.
import pipeline_defs::*;

module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        flush,
  output logic        dmem_req_valid,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [1:0]  dmem_req_size,
  input  logic        dmem_req_ready,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_hold,
  output logic [31:0] load_data,
  output logic        load_data_valid,
  output logic        misaligned_exc,
  output logic        bus_error
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             op, aligned, timeout;
  logic             capture;
  logic [31:0]      ext_data;

  assign op      = is_load | is_store;
  assign aligned = is_aligned(mem_size, addr[1:0]);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Request fields come straight from the held pipeline register.
  assign dmem_req_we    = is_store;
  assign dmem_req_addr  = addr;
  assign dmem_req_wdata = store_data;
  assign dmem_req_size  = mem_size;

  load_extend u_ext (
    .rdata       (dmem_rdata),
    .addr        (addr[1:0]),
    .size        (mem_size),
    .is_unsigned (load_unsigned),
    .data        (ext_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if ((state_q == S_WAIT || state_q == S_DRAIN)
                 && state_d == state_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_data <= '0;
    end else if (capture) begin
      load_data <= ext_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    stall_hold      = 1'b0;
    dmem_req_valid  = 1'b0;
    load_data_valid = 1'b0;
    misaligned_exc  = 1'b0;
    bus_error       = 1'b0;
    capture         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (op && !flush) begin
          if (aligned) begin
            stall_hold = 1'b1;
            state_d    = S_REQ;
          end else begin
            misaligned_exc = 1'b1;
          end
        end
      end
      S_REQ: begin
        stall_hold     = 1'b1;
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) begin
          if (flush)         state_d = S_DRAIN;
          else if (is_store) state_d = S_DONE;
          else               state_d = S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_hold = 1'b1;
        // A flushed response in the same cycle needs no drain.
        if (dmem_resp_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            capture = 1'b1;
            state_d = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end else if (timeout) begin
          bus_error = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DRAIN: begin
        stall_hold = 1'b1;
        if (dmem_resp_valid || timeout) state_d = S_IDLE;
      end
      S_DONE: begin
        load_data_valid = is_load & ~flush;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl
// (TIMEOUT_CYCLES = 4).
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_load, is_store;
  logic [1:0]  mem_size;
  logic        load_unsigned;
  logic [31:0] addr, store_data;
  logic        flush;
  logic        dmem_req_valid, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [1:0]  dmem_req_size;
  logic        dmem_req_ready;
  logic        dmem_resp_valid;
  logic [31:0] dmem_rdata;
  logic        stall_hold;
  logic [31:0] load_data;
  logic        load_data_valid;
  logic        misaligned_exc, bus_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_load         (is_load),
    .is_store        (is_store),
    .mem_size        (mem_size),
    .load_unsigned   (load_unsigned),
    .addr            (addr),
    .store_data      (store_data),
    .flush           (flush),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_we     (dmem_req_we),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_size   (dmem_req_size),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata),
    .stall_hold      (stall_hold),
    .load_data       (load_data),
    .load_data_valid (load_data_valid),
    .misaligned_exc  (misaligned_exc),
    .bus_error       (bus_error)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_reqv"}, dmem_req_valid, 0);
    chk({tag, "_ldv"}, load_data_valid, 0);
    chk({tag, "_mis"}, misaligned_exc, 0);
    chk({tag, "_berr"}, bus_error, 0);
  endtask

  task automatic run_load(input logic [31:0] a,
                          input logic [1:0] sz,
                          input logic uns,
                          input logic [31:0] rd,
                          input logic [31:0] exp,
                          input string tag);
    is_load = 1; is_store = 0; mem_size = sz;
    load_unsigned = uns; addr = a;
    dmem_req_ready = 1; dmem_resp_valid = 0;
    #1;
    chk({tag, "_t0_stall"}, stall_hold, 1);
    chk({tag, "_t0_reqv"}, dmem_req_valid, 0);
    cyc();
    chk({tag, "_t1_reqv"}, dmem_req_valid, 1);
    chk({tag, "_t1_we"}, dmem_req_we, 0);
    chk({tag, "_t1_addr"}, dmem_req_addr, a);
    cyc();
    dmem_resp_valid = 1; dmem_rdata = rd;
    #1;
    chk({tag, "_t2_stall"}, stall_hold, 1);
    chk({tag, "_t2_ldv"}, load_data_valid, 0);
    cyc();
    dmem_resp_valid = 0;
    #1;
    chk({tag, "_t3_ldv"}, load_data_valid, 1);
    chk({tag, "_t3_data"}, load_data, exp);
    chk({tag, "_t3_stall"}, stall_hold, 0);
    cyc();
    is_load = 0;
    #1;
    chk({tag, "_t4_ldv"}, load_data_valid, 0);
    chk({tag, "_t4_stall"}, stall_hold, 0);
  endtask

  initial begin
    reset = 0; is_load = 0; is_store = 0; mem_size = 2'b10;
    load_unsigned = 0; addr = 0; store_data = 0; flush = 0;
    dmem_req_ready = 0; dmem_resp_valid = 0; dmem_rdata = 0;
    #2;
    chk("rst_stall", stall_hold, 0);
    chk("rst_data", load_data, 0);
    chk_quiet("rst");
    cyc();
    reset = 1;
    cyc();

    // Word load, immediate ready and response
    run_load(32'h100, 2'b10, 0, 32'hDEADBEEF, 32'hDEADBEEF, "lw");

    // Byte lane 3, signed then unsigned
    run_load(32'h103, 2'b00, 0, 32'h80123456, 32'hFFFFFF80, "lb");
    run_load(32'h103, 2'b00, 1, 32'h80123456, 32'h00000080, "lbu");
    // Half loads on upper and lower lanes
    run_load(32'h102, 2'b01, 0, 32'h80017FFF, 32'hFFFF8001, "lh");
    run_load(32'h100, 2'b01, 1, 32'h1234F00F, 32'h0000F00F, "lhu");
    // Byte lane 1 signed positive
    run_load(32'h101, 2'b00, 0, 32'hAA5511CC, 32'h00000011, "lb1");

    // Store half with ready low for 4 cycles
    cyc();
    is_store = 1; mem_size = 2'b01; addr = 32'h202;
    store_data = 32'hCAFE1234; dmem_req_ready = 0;
    #1;
    chk("sh_t0_stall", stall_hold, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("sh_wait_reqv", dmem_req_valid, 1);
      chk("sh_wait_we", dmem_req_we, 1);
      chk("sh_wait_addr", dmem_req_addr, 32'h202);
      chk("sh_wait_size", dmem_req_size, 2'b01);
      chk("sh_wait_wdata", dmem_req_wdata, 32'hCAFE1234);
      chk("sh_wait_stall", stall_hold, 1);
      cyc();
    end
    dmem_req_ready = 1;
    #1;
    chk("sh_acc_reqv", dmem_req_valid, 1);
    cyc();
    chk("sh_done_stall", stall_hold, 0);
    chk("sh_done_reqv", dmem_req_valid, 0);
    chk("sh_done_ldv", load_data_valid, 0);
    cyc();
    is_store = 0;
    #1;
    chk_quiet("sh_idle");

    // Misaligned word load
    cyc();
    is_load = 1; mem_size = 2'b10; addr = 32'h101;
    #1;
    chk("mis_exc", misaligned_exc, 1);
    chk("mis_stall", stall_hold, 0);
    chk("mis_reqv", dmem_req_valid, 0);
    cyc();
    is_load = 0;
    #1;
    chk("mis_exc_end", misaligned_exc, 0);
    chk("mis_reqv_end", dmem_req_valid, 0);

    // Timeout: no response, TIMEOUT_CYCLES = 4
    cyc();
    is_load = 1; mem_size = 2'b10; addr = 32'h300;
    dmem_req_ready = 1; dmem_resp_valid = 0;
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_berr", bus_error, 0);
      chk("to_wait_stall", stall_hold, 1);
      cyc();
    end
    chk("to_berr", bus_error, 1);
    is_load = 0;
    cyc();
    chk("to_idle_stall", stall_hold, 0);
    chk_quiet("to_idle");

    // Flush in WAIT, response 2 cycles later
    cyc();
    is_load = 1; mem_size = 2'b10; addr = 32'h400;
    dmem_req_ready = 1;
    cyc();
    cyc();
    flush = 1;
    #1;
    chk("fw_stall", stall_hold, 1);
    cyc();
    flush = 0; is_load = 0;
    #1;
    chk("fw_drain_stall", stall_hold, 1);
    cyc();
    dmem_resp_valid = 1; dmem_rdata = 32'h11111111;
    #1;
    chk("fw_drain_ldv", load_data_valid, 0);
    chk("fw_drain_berr", bus_error, 0);
    cyc();
    dmem_resp_valid = 0;
    #1;
    chk("fw_idle_stall", stall_hold, 0);
    chk_quiet("fw_idle");
    run_load(32'h104, 2'b10, 0, 32'h0BADF00D, 32'h0BADF00D, "lw2");

    // Stray response in IDLE is ignored
    dmem_resp_valid = 1; dmem_rdata = 32'h55555555;
    cyc();
    dmem_resp_valid = 0;
    #1;
    chk("stray_data", load_data, 32'h0BADF00D);
    chk("stray_ldv", load_data_valid, 0);

    // Flush in DONE suppresses load_data_valid
    is_load = 1; mem_size = 2'b10; addr = 32'h108;
    dmem_req_ready = 1;
    cyc();
    cyc();
    dmem_resp_valid = 1; dmem_rdata = 32'h12345678;
    cyc();
    dmem_resp_valid = 0; flush = 1;
    #1;
    chk("fd_ldv", load_data_valid, 0);
    chk("fd_stall", stall_hold, 0);
    cyc();
    flush = 0; is_load = 0;
    #1;
    chk_quiet("fd_idle");

    // Flush in REQ before handshake
    is_load = 1; addr = 32'h10C; dmem_req_ready = 0;
    cyc();
    flush = 1;
    #1;
    chk("fr_reqv", dmem_req_valid, 1);
    cyc();
    flush = 0; is_load = 0;
    #1;
    chk("fr_stall", stall_hold, 0);
    chk_quiet("fr_idle");

    // Asynchronous reset mid-access
    is_load = 1; addr = 32'h110; dmem_req_ready = 0;
    cyc();
    chk("ar_reqv_before", dmem_req_valid, 1);
    reset = 0;
    #1;
    chk("ar_reqv", dmem_req_valid, 0);
    chk("ar_data", load_data, 0);
    is_load = 0;
    #1;
    chk("ar_stall", stall_hold, 0);
    cyc();
    reset = 1;
    dmem_resp_valid = 1; dmem_rdata = 32'h77777777;
    cyc();
    dmem_resp_valid = 0;
    #1;
    chk("ar_late_ldv", load_data_valid, 0);
    chk("ar_late_data", load_data, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
